// File: rtl/fetch_pc_stage.sv
// Fetch stage: owns PC_F, issues one req/gnt/rvalid instruction fetch at a time and fills IF/ID.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_next,
  input  logic            REDIRECT,
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] PC_plus_4_F,
  output logic            ADVANCE_F,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            STALL_D,
  output logic            VALID_D,
  output logic [XLEN-1:0] INSTR_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PC_plus_4_D,
  output logic [XLEN-1:0] FETCH_CNT,
  output logic [XLEN-1:0] STALL_CNT
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [1:0]      state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            valid_d_q, valid_d_d;
  logic [XLEN-1:0] instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pc_plus_4_d_q, pc_plus_4_d_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            advance;
  logic            load_en;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;
  logic            slot_free;
  logic [XLEN-1:0] pc_next_al;

  assign slot_free  = !valid_d_q || !STALL_D;
  assign pc_next_al = {PC_next[XLEN-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    pc_f_d        = pc_f_q;
    valid_d_d     = valid_d_q;
    instr_d_d     = instr_d_q;
    pc_d_d        = pc_d_q;
    pc_plus_4_d_d = pc_plus_4_d_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    advance       = 1'b0;
    load_en       = 1'b0;
    load_instr    = '0;
    load_pc       = '0;

    if (REDIRECT) begin
      // Redirect wins over everything; a grant taken this cycle belongs to the old PC.
      advance   = 1'b1;
      pc_f_d    = pc_next_al;
      valid_d_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (IMEM_GNT) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (IMEM_RVALID) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      if (slot_free) valid_d_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (IMEM_GNT) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_RVALID) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              // PC_F still names this fetch until the accept below moves it on.
              advance = 1'b1;
              pc_f_d  = pc_next_al;
              if (slot_free) begin
                load_en    = 1'b1;
                load_instr = IMEM_RDATA;
                load_pc    = pc_f_q;
              end else begin
                hold_instr_d = IMEM_RDATA;
                hold_pc_d    = pc_f_q;
                state_d      = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            load_en    = 1'b1;
            load_instr = hold_instr_q;
            load_pc    = hold_pc_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      if (load_en) begin
        valid_d_d     = 1'b1;
        instr_d_d     = load_instr;
        pc_d_d        = load_pc;
        pc_plus_4_d_d = load_pc + FOUR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      kill_q        <= 1'b0;
      pc_f_q        <= RESET_PC;
      valid_d_q     <= 1'b0;
      instr_d_q     <= '0;
      pc_d_q        <= '0;
      pc_plus_4_d_q <= '0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      pc_f_q        <= pc_f_d;
      valid_d_q     <= valid_d_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      pc_plus_4_d_q <= pc_plus_4_d_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load_en && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + XLEN'(1);
    if (valid_d_q && STALL_D && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + XLEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`else
  assign FETCH_CNT = '0;
  assign STALL_CNT = '0;
`endif

  assign PC_F        = pc_f_q;
  assign PC_plus_4_F = pc_f_q + FOUR;
  assign ADVANCE_F   = advance;
  assign IMEM_REQ    = (state_q == S_REQ);
  assign IMEM_ADDR   = pc_f_q;
  assign VALID_D     = valid_d_q;
  assign INSTR_D     = instr_d_q;
  assign PC_D        = pc_d_q;
  assign PC_plus_4_D = pc_plus_4_d_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Table-driven bench for fetch_pc_stage: per-cycle vectors plus reset-mid-fetch and counter sequences.
module tb_fetch_pc_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] W_A = 32'hA000_0013, W_B = 32'hB000_0013, W_C = 32'hC000_0013;
  localparam logic [31:0] W_D = 32'hD000_0013, W_E = 32'hE000_0013, W_F = 32'hF000_0013;
  localparam logic [31:0] W_H = 32'h1100_0013, W_I = 32'h2200_0013, W_J = 32'h3300_0013;
  localparam logic [31:0] W_K = 32'h4400_0013, W_L = 32'h5500_0013, W_M = 32'h6600_0013;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF, JUNK = 32'hBAAD_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_next;
  logic        REDIRECT = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] PC_F, PC_plus_4_F, IMEM_ADDR, INSTR_D, PC_D, PC_plus_4_D, FETCH_CNT, STALL_CNT;
  logic        ADVANCE_F, IMEM_REQ, VALID_D;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        STALL_D = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the PC select mux: sequential PC unless redirecting.
  always_comb PC_next = REDIRECT ? tgt : PC_plus_4_F;

  fetch_pc_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PC_next(PC_next), .REDIRECT(REDIRECT),
    .PC_F(PC_F), .PC_plus_4_F(PC_plus_4_F), .ADVANCE_F(ADVANCE_F),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .STALL_D(STALL_D),
    .VALID_D(VALID_D), .INSTR_D(INSTR_D), .PC_D(PC_D), .PC_plus_4_D(PC_plus_4_D),
    .FETCH_CNT(FETCH_CNT), .STALL_CNT(STALL_CNT)
  );

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        req;
    logic        adv;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic redir, logic [31:0] t, logic gnt, logic rv, logic [31:0] rdata,
                              logic stall, logic req, logic adv, logic valid, logic [31:0] instr,
                              logic [31:0] pcd, logic [31:0] pcf);
    vec_t v;
    v.redir = redir; v.tgt = t; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = stall;
    v.req = req; v.adv = adv; v.valid = valid; v.instr = instr; v.pcd = pcd; v.pcf = pcf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] t, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic stall);
    REDIRECT = redir; tgt = t; IMEM_GNT = gnt; IMEM_RVALID = rv; IMEM_RDATA = rdata; STALL_D = stall;
  endtask

  task automatic cyc(input logic gnt, input logic rv, input logic [31:0] rdata, input logic stall);
    drive(1'b0, '0, gnt, rv, rdata, stall);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] prev_pcf;
    logic [31:0] exp_fetch, exp_stall;

    // redir tgt gnt rv rdata stall | req adv | valid instr pc_d pc_f (after edge)
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, 0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 1, W_A,   0, 0, 1, 1, W_A, 0,   4));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_A, 0,   4));
    tbl.push_back(mk(0, 0, 0, 1, W_B,   0, 0, 1, 1, W_B, 4,   8));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_B, 4,   8));
    tbl.push_back(mk(0, 0, 0, 1, W_C,   0, 0, 1, 1, W_C, 8,   12));
    tbl.push_back(mk(0, 0, 1, 0, 0,     1, 1, 0, 1, W_C, 8,   12));
    tbl.push_back(mk(0, 0, 0, 1, W_D,   1, 0, 1, 1, W_C, 8,   16));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 1, W_C, 8,   16));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 1, W_C, 8,   16));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 1, W_C, 8,   16));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 1, W_D, 12,  16));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_D, 12,  16));
    tbl.push_back(mk(0, 0, 0, 1, W_E,   0, 0, 1, 1, W_E, 16,  20));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_E, 16,  20));
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, W_E, 16, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0, W_E, 16,  32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0, W_E, 16,  32'h100));
    tbl.push_back(mk(0, 0, 0, 1, STALE, 0, 0, 0, 0, W_E, 16,  32'h100));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_E, 16,  32'h100));
    tbl.push_back(mk(0, 0, 0, 1, W_F,   0, 0, 1, 1, W_F, 32'h100, 32'h104));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_F, 32'h100, 32'h104));
    tbl.push_back(mk(1, 32'h200, 0, 1, STALE, 0, 0, 1, 0, W_F, 32'h100, 32'h200));
    tbl.push_back(mk(1, 32'h300, 1, 0, 0, 0, 1, 1, 0, W_F, 32'h100, 32'h300));
    tbl.push_back(mk(0, 0, 0, 1, STALE, 0, 0, 0, 0, W_F, 32'h100, 32'h300));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_F, 32'h100, 32'h300));
    tbl.push_back(mk(0, 0, 0, 1, W_H,   0, 0, 1, 1, W_H, 32'h300, 32'h304));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 1, 1, 1, 0, W_H, 32'h300, 32'h400));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_H, 32'h300, 32'h400));
    tbl.push_back(mk(0, 0, 0, 1, W_I,   0, 0, 1, 1, W_I, 32'h400, 32'h404));
    tbl.push_back(mk(0, 0, 1, 0, 0,     1, 1, 0, 1, W_I, 32'h400, 32'h404));
    tbl.push_back(mk(0, 0, 0, 1, W_J,   1, 0, 1, 1, W_I, 32'h400, 32'h408));
    tbl.push_back(mk(1, 32'h503, 0, 0, 0, 1, 0, 1, 0, W_I, 32'h400, 32'h500));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_I, 32'h400, 32'h500));
    tbl.push_back(mk(0, 0, 0, 1, W_K,   0, 0, 1, 1, W_K, 32'h500, 32'h504));
    tbl.push_back(mk(0, 0, 0, 1, JUNK,  0, 1, 0, 0, W_K, 32'h500, 32'h504));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 1, 0, W_K, 32'h500, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_K, 32'h500, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 0, 1, W_L,   0, 0, 1, 1, W_L, 32'hFFFF_FFFC, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_L, 32'hFFFF_FFFC, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, W_M,   0, 0, 1, 1, W_M, 32'h0, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 0,     0, 1, 0, 0, W_M, 32'h0, 32'h4));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset PC_F", PC_F, RESET_PC);
    chk("reset VALID_D", 32'(VALID_D), 32'h0);
    chk("reset INSTR_D", INSTR_D, 32'h0);
    chk("reset PC_D", PC_D, 32'h0);
    chk("reset PC_plus_4_D", PC_plus_4_D, 32'h0);
    chk("reset IMEM_REQ", 32'(IMEM_REQ), 32'h1);
    chk("reset FETCH_CNT", FETCH_CNT, 32'h0);
    chk("reset STALL_CNT", STALL_CNT, 32'h0);

    prev_pcf = RESET_PC;
    foreach (tbl[i]) begin
      drive(tbl[i].redir, tbl[i].tgt, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].stall);
      #1;
      chk($sformatf("v%0d IMEM_REQ", i), 32'(IMEM_REQ), 32'(tbl[i].req));
      chk($sformatf("v%0d ADVANCE_F", i), 32'(ADVANCE_F), 32'(tbl[i].adv));
      chk($sformatf("v%0d IMEM_ADDR", i), IMEM_ADDR, prev_pcf);
      chk($sformatf("v%0d PC_plus_4_F", i), PC_plus_4_F, prev_pcf + 32'd4);
      @(posedge clk); #1;
      chk($sformatf("v%0d VALID_D", i), 32'(VALID_D), 32'(tbl[i].valid));
      chk($sformatf("v%0d INSTR_D", i), INSTR_D, tbl[i].instr);
      chk($sformatf("v%0d PC_D", i), PC_D, tbl[i].pcd);
      chk($sformatf("v%0d PC_F", i), PC_F, tbl[i].pcf);
      if (tbl[i].valid) chk($sformatf("v%0d PC_plus_4_D", i), PC_plus_4_D, tbl[i].pcd + 32'd4);
      prev_pcf = tbl[i].pcf;
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Async reset while a fetch is outstanding; the late response must be ignored.
    #2 rst = 1'b1;
    #1;
    chk("midrst PC_F", PC_F, RESET_PC);
    chk("midrst VALID_D", 32'(VALID_D), 32'h0);
    chk("midrst INSTR_D", INSTR_D, 32'h0);
    chk("midrst PC_D", PC_D, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, JUNK, 1'b0);
    #1;
    chk("late rvalid ADVANCE_F", 32'(ADVANCE_F), 32'h0);
    chk("late rvalid IMEM_REQ", 32'(IMEM_REQ), 32'h1);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("late rvalid VALID_D", 32'(VALID_D), 32'h0);
    chk("late rvalid PC_F", PC_F, RESET_PC);
    chk("post-rst FETCH_CNT", FETCH_CNT, 32'h0);

    // Ten fetches; decode stalls during the grant cycle of fetches 1..3.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, '0, (i >= 1 && i <= 3));
      cyc(1'b0, 1'b1, W_A + 32'(i), 1'b0);
    end
    chk("cnt PC_D", PC_D, 32'd36);
    chk("cnt INSTR_D", INSTR_D, W_A + 32'd9);
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd10;
    exp_stall = 32'd3;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    chk("FETCH_CNT", FETCH_CNT, exp_fetch);
    chk("STALL_CNT", STALL_CNT, exp_stall);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
